// File: rtl/mult_div_unit_if.sv
// Bus bundle for the multiply/divide stage: launch request, operands,
// MTHI/MTLO write port, and the status/result signals back to the core.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is a one-bit-per-cycle shift-add on operand magnitudes; divide
// is a restoring divider sharing the same 2*WIDTH accumulator (upper half
// holds the partial remainder, lower half shifts the quotient in).
// Optional feature macro: DIVIDER_EN. When undefined no divider is built and
// DIVU/DIV complete after one cycle leaving HI/LO untouched.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clock,
   input  logic           resetn,
   mult_div_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} stateT;

   stateT              state;
   stateT              nextState;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   operand;
   logic [2*WIDTH-1:0] acc;
   logic               negResult;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               doneReg;
   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic               launch;
   logic [WIDTH:0]     addSum;
`ifdef DIVIDER_EN
   logic               isDiv;
   logic               negRem;
   logic               divZero;
   logic [WIDTH-1:0]   rawA;
   logic [WIDTH:0]     trialRem;
   logic [WIDTH:0]     trialDiff;
`else
   logic               nopLaunch;
   logic               nopPending;
`endif

   // Operand magnitudes: signed ops (op[0]=1) take the absolute value so the
   // iterative core only ever works on unsigned numbers.
   always_comb begin
      absA = bus.rs_data;
      absB = bus.rt_data;
      if (bus.op[0] && bus.rs_data[WIDTH-1]) absA = -bus.rs_data;
      if (bus.op[0] && bus.rt_data[WIDTH-1]) absB = -bus.rt_data;
   end

   // Launch decode: a start is only honoured in IDLE, so starts while busy fall away.
   always_comb begin
`ifdef DIVIDER_EN
      launch = (state == IDLE) && bus.start;
`else
      launch    = (state == IDLE) && bus.start && !bus.op[1];
      nopLaunch = (state == IDLE) && bus.start && bus.op[1];
`endif
   end

   // One iteration step: shift-add sum for multiply, trial subtraction for divide.
   always_comb begin
      addSum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) addSum = addSum + {1'b0, operand};
`ifdef DIVIDER_EN
      trialRem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trialDiff = trialRem - {1'b0, operand};
`endif
   end

   // State register; reset aborts anything in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= nextState;
   end

   // Next-state logic: RUN exits as the counter steps from 1 to 0.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (launch) nextState = RUN;
         RUN:     if (count == CW'(1)) nextState = FIXUP;
         FIXUP:   nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath and architectural HI/LO: operand capture, iteration, sign
   // correction, and the final result write with the done pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count     <= '0;
         operand   <= '0;
         acc       <= '0;
         negResult <= 1'b0;
         hiReg     <= '0;
         loReg     <= '0;
         doneReg   <= 1'b0;
`ifdef DIVIDER_EN
         isDiv     <= 1'b0;
         negRem    <= 1'b0;
         divZero   <= 1'b0;
         rawA      <= '0;
`else
         nopPending <= 1'b0;
`endif
      end else begin
         doneReg <= 1'b0;
`ifndef DIVIDER_EN
         nopPending <= nopLaunch;
         if (nopPending) doneReg <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (bus.hi_we) hiReg <= bus.wdata;
               if (bus.lo_we) loReg <= bus.wdata;
               if (launch) begin
                  count     <= CW'(WIDTH);
                  negResult <= bus.op[0] & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
`ifdef DIVIDER_EN
                  isDiv   <= bus.op[1];
                  negRem  <= bus.op[0] & bus.rs_data[WIDTH-1];
                  divZero <= (bus.rt_data == '0);
                  rawA    <= bus.rs_data;
                  if (bus.op[1]) begin
                     operand <= absB;
                     acc     <= {{WIDTH{1'b0}}, absA};
                  end else begin
                     operand <= absA;
                     acc     <= {{WIDTH{1'b0}}, absB};
                  end
`else
                  operand <= absA;
                  acc     <= {{WIDTH{1'b0}}, absB};
`endif
               end
            end
            RUN: begin
               count <= count - CW'(1);
`ifdef DIVIDER_EN
               if (isDiv) begin
                  if (!trialDiff[WIDTH])
                     acc <= {trialDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  else
                     acc <= {trialRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               end else begin
                  acc <= {addSum, acc[WIDTH-1:1]};
               end
`else
               acc <= {addSum, acc[WIDTH-1:1]};
`endif
            end
            FIXUP: begin
`ifdef DIVIDER_EN
               if (isDiv) begin
                  if (negResult) acc[WIDTH-1:0] <= -acc[WIDTH-1:0];
                  if (negRem)    acc[2*WIDTH-1:WIDTH] <= -acc[2*WIDTH-1:WIDTH];
               end else if (negResult) begin
                  acc <= -acc;
               end
`else
               if (negResult) acc <= -acc;
`endif
            end
            DONE: begin
               doneReg <= 1'b1;
`ifdef DIVIDER_EN
               if (isDiv && divZero) begin
                  hiReg <= rawA;
                  loReg <= '1;
               end else begin
                  hiReg <= acc[2*WIDTH-1:WIDTH];
                  loReg <= acc[WIDTH-1:0];
               end
`else
               hiReg <= acc[2*WIDTH-1:WIDTH];
               loReg <= acc[WIDTH-1:0];
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = doneReg;
   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a directed vector table, hand
// sequences for the multi-cycle hazards, and random operations checked
// against a plain-arithmetic reference model. Honours DIVIDER_EN.
module tb_mult_div_unit;

   localparam int WIDTH = 32;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vecT;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] modelHi    = '0;
   logic [31:0] modelLo    = '0;

   // Reference model: {hi, lo} from ordinary integer arithmetic.
   function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] prevHi,
                                            input logic [31:0] prevLo);
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      p = {prevHi, prevLo};
      case (op)
         2'b00: p = {32'd0, a} * {32'd0, b};
         2'b01: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         default: begin
`ifdef DIVIDER_EN
            if (b == 32'd0) begin
               p = {a, 32'hFFFF_FFFF};
            end else if (op == 2'b10) begin
               q = a / b;
               r = a % b;
               p = {r, q};
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               p = {32'd0, 32'h8000_0000};
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               p = {r, q};
            end
`endif
         end
      endcase
      return p;
   endfunction

   // Latency and busy expectation for an op in this build.
   function automatic int expectedLatency(input logic [1:0] op);
`ifdef DIVIDER_EN
      return (op == 2'b11) ? WIDTH + 2 : WIDTH + 2;
`else
      return op[1] ? 1 : WIDTH + 2;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one launch, scramble the operands after the start edge, and wait
   // (bounded) for done. Returns latency in cycles after the start edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int latency, output logic busyStart,
                                output logic busyDone);
      @(negedge clock);
      bus.op      = op;
      bus.rs_data = a;
      bus.rt_data = b;
      bus.start   = 1'b1;
      @(posedge clock);
      #1;
      bus.start   = 1'b0;
      bus.rs_data = $urandom;
      bus.rt_data = $urandom;
      busyStart   = bus.busy;
      busyDone    = 1'b1;
      latency     = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            latency  = k;
            busyDone = bus.busy;
            break;
         end
      end
   endtask

   task automatic runCase(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expHi,
                          input logic [31:0] expLo);
      int   lat;
      int   expLat;
      logic busyStart;
      logic busyDone;
      expLat = expectedLatency(op);
      applyStimulus(op, a, b, lat, busyStart, busyDone);
      checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, " busyAfterStart"}, 64'(busyStart), 64'(expLat != 1));
      checkOutput({tag, " busyAtDone"}, 64'(busyDone), 64'd0);
      checkOutput({tag, " hi"}, 64'(bus.hi), 64'(expHi));
      checkOutput({tag, " lo"}, 64'(bus.lo), 64'(expLo));
      modelHi = expHi;
      modelLo = expLo;
   endtask

   vecT         vecs[12];
   logic [63:0] expect64;
   logic [1:0]  rOp;
   logic [31:0] rA;
   logic [31:0] rB;
   logic        sawDone;
   int          lat;

   initial begin
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      bus.wdata   = '0;

      vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6]  = '{2'b00, 32'd0,         32'h0000_0123, 32'h0000_0000, 32'h0000_0000};
      vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8]  = '{2'b01, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
      vecs[10] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[11] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset hi", 64'(bus.hi), 64'd0);
      checkOutput("reset lo", 64'(bus.lo), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      @(negedge clock);
      resetn = 1'b1;

      // MTHI / MTLO in IDLE
      @(negedge clock);
      bus.hi_we = 1'b1;
      bus.wdata = 32'hA5A5_A5A5;
      @(negedge clock);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h5A5A_5A5A;
      @(negedge clock);
      bus.lo_we = 1'b0;
      checkOutput("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
      checkOutput("mtlo", 64'(bus.lo), 64'h5A5A_5A5A);
      modelHi = 32'hA5A5_A5A5;
      modelLo = 32'h5A5A_5A5A;

      // Directed table (consecutive entries also exercise back-to-back starts)
      for (int i = 0; i < 12; i++) begin
         expect64 = {vecs[i].expHi, vecs[i].expLo};
`ifndef DIVIDER_EN
         if (vecs[i].op[1]) expect64 = {modelHi, modelLo};
`endif
         runCase($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 expect64[63:32], expect64[31:0]);
      end

      // Collision: MTHI and a second start while busy are both ignored
      @(negedge clock);
      bus.op = 2'b00; bus.rs_data = 32'h10; bus.rt_data = 32'h20; bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      bus.hi_we = 1'b1;
      bus.wdata = 32'h1234_5678;
      @(posedge clock);
      #1;
      bus.hi_we = 1'b0;
      checkOutput("busy mthi ignored", 64'(bus.hi), 64'(modelHi));
      @(posedge clock);
      #1;
      bus.op = 2'b00; bus.rs_data = 32'd3; bus.rt_data = 32'd3; bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      lat = -1;
      for (int k = 6; k <= 60; k++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      checkOutput("collision latency", 64'(lat), 64'(WIDTH + 2));
      checkOutput("collision hi", 64'(bus.hi), 64'h0);
      checkOutput("collision lo", 64'(bus.lo), 64'h200);

      // start together with MTHI/MTLO in IDLE: write lands, result overwrites
      @(negedge clock);
      bus.op = 2'b00; bus.rs_data = 32'd5; bus.rt_data = 32'd6; bus.start = 1'b1;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      @(posedge clock);
      #1;
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      checkOutput("startWrite hi", 64'(bus.hi), 64'hDEAD_BEEF);
      checkOutput("startWrite lo", 64'(bus.lo), 64'hDEAD_BEEF);
      checkOutput("startWrite busy", 64'(bus.busy), 64'd1);
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      checkOutput("startWrite latency", 64'(lat), 64'(WIDTH + 2));
      checkOutput("startWrite result hi", 64'(bus.hi), 64'd0);
      checkOutput("startWrite result lo", 64'(bus.lo), 64'd30);
      modelHi = 32'd0;
      modelLo = 32'd30;

      // Random operations against the reference model
      for (int i = 0; i < 24; i++) begin
         rOp = 2'($urandom_range(0, 3));
         rA  = $urandom;
         rB  = $urandom;
         case ($urandom_range(0, 7))
            0: rB = 32'd0;
            1: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
            2: rB = 32'($urandom_range(1, 15));
            default: ;
         endcase
         expect64 = refModel(rOp, rA, rB, modelHi, modelLo);
         runCase($sformatf("rand%0d op%0d", i, rOp), rOp, rA, rB,
                 expect64[63:32], expect64[31:0]);
      end

      // Reset in the middle of a multiply: no partial update, no done
      runCase("preReset", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      @(negedge clock);
      bus.op = 2'b00; bus.rs_data = 32'h1234; bus.rt_data = 32'h5678; bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("midReset hi", 64'(bus.hi), 64'd0);
      checkOutput("midReset lo", 64'(bus.lo), 64'd0);
      checkOutput("midReset busy", 64'(bus.busy), 64'd0);
      checkOutput("midReset done", 64'(bus.done), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      sawDone = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (bus.done) sawDone = 1'b1;
      end
      checkOutput("midReset noDone", 64'(sawDone), 64'd0);
      checkOutput("midReset hi held", 64'(bus.hi), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide stage with architectural HI/LO registers. It sits directly downstream of the register file and consumes the two read-port operands (rs, rt) on MULT/MULTU/DIV/DIVU. It produces a 64-bit result into HI/LO over multiple cycles while the core keeps issuing independent instructions. It also services MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO path.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  launch request; sampled on posedge.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_data  in  WIDTH  operand A (multiplicand / dividend), from register-file ReadData1.
- rt_data  in  WIDTH  operand B (multiplier / divisor), from register-file ReadData2.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO take a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - start=1 latches op and operands, and sets the iteration counter to WIDTH.
  - Signed ops (MULT, DIV) latch operand magnitudes and record the signs.
  - Next state is RUN.
- RUN processes one bit per cycle while the counter decrements. It leaves for FIXUP when the counter reaches 0.
  - Multiply: unsigned shift-add of the magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division of the magnitudes, producing quotient and remainder.
- FIXUP applies signed-result correction:
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- DONE:
  - Writes HI/LO and pulses done, then returns to IDLE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (either signedness) gives a defined result: HI = dividend (raw rs_data), LO = all ones. It takes the normal latency.
- DIV of most-negative by -1: LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata on the next posedge.
  - While busy, they are ignored and HI/LO hold.
- start while busy is ignored; the in-flight operation is not restarted.
- start together with hi_we/lo_we in IDLE: the write takes effect and the operation launches. The final result later overwrites HI/LO.
- Operands are sampled only on the start edge. Later changes on rs_data/rt_data have no effect.

## Timing
- Reset (async, resetn=0): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0. Any in-flight operation is aborted with no partial HI/LO update.
- For a start accepted at edge T:
  - busy = 1 from T until edge T+WIDTH+2.
  - At edge T+WIDTH+2, HI/LO update, done = 1 for one cycle, and busy = 0.
  - With WIDTH=32, results are visible 34 cycles after start.
- Back-to-back: start may be reasserted in the cycle done is high. That start is accepted at the next edge (IDLE).
- hi/lo are registered outputs, never combinational from the inputs.

## Configuration
- DIVIDER_EN:
  - Defined: full DIVU/DIV support as above.
  - Undefined:
    - No divider datapath is synthesised.
    - op 10/11 is accepted, HI/LO are left unchanged, and busy stays 0.
    - done pulses at edge T+1.
    - Multiply behaviour and latency are unchanged.

## Test plan
- Reset mid-multiply: start MULTU at T, drop resetn at T+10 -> hi=0, lo=0, busy=0, no done pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFF × 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF.
- Collision and hazard checks:
  - hi_we with wdata=0x12345678 while busy -> hi unchanged; the final result is written.
  - start pulsed at T+5 -> ignored.
  - With DIVIDER_EN undefined, DIVU -> done at T+1, HI/LO unchanged.
